// File: rtl/vz_image_loader.sv
// VZ image loader: parses the header, buffers body bytes in a FIFO, writes RAM, patches pointers, requests exec.
// Optional body checksum: define VZ_LOADER_CHECKSUM_EN.
module vz_image_loader #(
    parameter int unsigned HDR_LEN    = 24,
    parameter int unsigned TYPE_OFS   = 21,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  BASIC_TYPE = 8'hF0,
    parameter logic [7:0]  MCODE_TYPE = 8'hF1
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [23:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic [15:0] execute_addr,
    output logic        execute_enable,
    input  logic        execute_ack,
    output logic        busy,
    output logic        led,
    output logic        load_error,
    output logic [15:0] checksum
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_WAIT = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [23:0] OFS_TYPE = 24'(TYPE_OFS);
    localparam logic [23:0] OFS_LO   = 24'(TYPE_OFS + 1);
    localparam logic [23:0] OFS_HI   = 24'(TYPE_OFS + 2);
    localparam logic [23:0] OFS_LAST = 24'(HDR_LEN - 1);

    typedef enum logic [2:0] {IDLE, HEADER, BODY, DRAIN, PATCH, EXEC, ERROR} state_t;

    state_t           state;
    logic             dl_q;
    logic [7:0]       img_type;
    logic [15:0]      start_addr;
    logic [15:0]      cur_addr;
    logic [15:0]      fifo_addr [FIFO_DEPTH];
    logic [7:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] fifo_cnt_next;
    logic [3:0]       patch_idx;

    logic             dl_rise;
    logic             dl_fall;
    logic             strobe;
    logic             out_free;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             overflow;
    logic             hdr_last;
    logic [7:0]       type_next;
    logic [15:0]      start_next;
    logic [3:0]       patch_len;
    logic [15:0]      patch_addr;
    logic [7:0]       patch_data;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign strobe   = ioctl_download & ioctl_wr & ~dl_rise;
    assign out_free = ~mem_wr | mem_ack;
    assign pop      = ((state == BODY) || (state == DRAIN)) && (fifo_cnt != '0) && out_free;
    assign push_req = (state == BODY) && strobe;
    // A pop on the same edge frees a slot, so a full FIFO can still accept the byte.
    assign push     = push_req && ((fifo_cnt != CNT_FULL) || pop);
    assign overflow = push_req && !push;
    assign hdr_last = (state == HEADER) && strobe && (ioctl_addr == OFS_LAST);

    assign fifo_cnt_next = dl_rise ? '0 : (fifo_cnt + CNT_W'(push) - CNT_W'(pop));

    assign busy = (state != IDLE) && (state != ERROR);
    assign led  = (state == BODY) || (state == DRAIN) || (state == PATCH) || (state == EXEC);

    // Start hi may arrive on the last header byte, so the header decision uses these next values.
    always_comb begin
        type_next  = img_type;
        start_next = start_addr;
        if ((state == HEADER) && strobe) begin
            if (ioctl_addr == OFS_TYPE) type_next = ioctl_data;
            if (ioctl_addr == OFS_LO) start_next[7:0] = ioctl_data;
            if (ioctl_addr == OFS_HI) start_next[15:8] = ioctl_data;
        end
    end

    always_comb begin
        patch_len  = (img_type == BASIC_TYPE) ? 4'd8 : 4'd2;
        patch_addr = 16'h0000;
        patch_data = 8'h00;
        if (img_type == BASIC_TYPE) begin
            case (patch_idx[2:0])
                3'd0: begin patch_addr = 16'h78A5; patch_data = start_addr[15:8]; end
                3'd1: begin patch_addr = 16'h78A4; patch_data = start_addr[7:0];  end
                3'd2: begin patch_addr = 16'h78FA; patch_data = cur_addr[15:8];   end
                3'd3: begin patch_addr = 16'h78F9; patch_data = cur_addr[7:0];    end
                3'd4: begin patch_addr = 16'h78FC; patch_data = cur_addr[15:8];   end
                3'd5: begin patch_addr = 16'h78FB; patch_data = cur_addr[7:0];    end
                3'd6: begin patch_addr = 16'h78FE; patch_data = cur_addr[15:8];   end
                default: begin patch_addr = 16'h78FD; patch_data = cur_addr[7:0]; end
            endcase
        end else begin
            patch_addr = patch_idx[0] ? 16'h788E : 16'h788F;
            patch_data = patch_idx[0] ? start_addr[7:0] : start_addr[15:8];
        end
    end

    always_ff @(posedge I_CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cur_addr;
            fifo_data[wr_ptr] <= ioctl_data;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            fifo_cnt   <= fifo_cnt_next;
            ioctl_wait <= (fifo_cnt_next >= CNT_WAIT);
            if (dl_rise) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Output register: refilled from the FIFO or patch table whenever the previous write retires.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state          <= IDLE;
            dl_q           <= 1'b0;
            img_type       <= 8'h00;
            start_addr     <= 16'h0000;
            cur_addr       <= 16'h0000;
            patch_idx      <= 4'd0;
            mem_addr       <= 16'h0000;
            mem_data       <= 8'h00;
            mem_wr         <= 1'b0;
            execute_addr   <= 16'h0000;
            execute_enable <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                state          <= HEADER;
                load_error     <= 1'b0;
                patch_idx      <= 4'd0;
                mem_wr         <= 1'b0;
                execute_enable <= 1'b0;
            end else begin
                if (pop) begin
                    mem_addr <= fifo_addr[rd_ptr];
                    mem_data <= fifo_data[rd_ptr];
                    mem_wr   <= 1'b1;
                end else if (mem_wr && mem_ack) begin
                    mem_wr <= 1'b0;
                end
                if (overflow) load_error <= 1'b1;
                case (state)
                    HEADER: begin
                        img_type   <= type_next;
                        start_addr <= start_next;
                        if (dl_fall) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else if (hdr_last) begin
                            if ((type_next != BASIC_TYPE) && (type_next != MCODE_TYPE)) begin
                                state      <= ERROR;
                                load_error <= 1'b1;
                            end else begin
                                cur_addr <= start_next;
                                state    <= BODY;
                            end
                        end
                    end
                    BODY: begin
                        if (push_req) cur_addr <= cur_addr + 16'd1;
                        if (dl_fall) state <= DRAIN;
                    end
                    DRAIN: begin
                        if ((fifo_cnt == '0) && out_free) state <= PATCH;
                    end
                    PATCH: begin
                        if (out_free) begin
                            if (patch_idx != patch_len) begin
                                mem_addr  <= patch_addr;
                                mem_data  <= patch_data;
                                mem_wr    <= 1'b1;
                                patch_idx <= patch_idx + 4'd1;
                            end else if (img_type == MCODE_TYPE) begin
                                state          <= EXEC;
                                execute_addr   <= start_addr;
                                execute_enable <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    EXEC: begin
                        if (execute_ack) begin
                            execute_enable <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef VZ_LOADER_CHECKSUM_EN
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            checksum <= 16'h0000;
        end else if (dl_rise) begin
            checksum <= 16'h0000;
        end else if (push) begin
            checksum <= checksum + {8'h00, ioctl_data};
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vz_image_loader.sv
// Scoreboard bench for vz_image_loader: randomized VZ downloads checked against an image-level reference model.
module tb_vz_image_loader;
    localparam int         HDR_LEN    = 24;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] BASIC      = 8'hF0;
    localparam logic [7:0] MCODE      = 8'hF1;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          droppable;
    } wr_t;

    logic        I_CLK = 1'b0;
    logic        I_RST;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [23:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic        mem_ack;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic        execute_ack;
    logic        busy;
    logic        led;
    logic        load_error;
    logic [15:0] checksum;

    wr_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          ack_mode = 1;
    bit          exec_allowed = 1'b0;
    int          body_seen = 0;
    bit          stall_valid = 1'b0;
    logic [15:0] stall_addr;
    logic [7:0]  stall_data;

    vz_image_loader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .execute_addr(execute_addr), .execute_enable(execute_enable), .execute_ack(execute_ack),
        .busy(busy), .led(led), .load_error(load_error), .checksum(checksum)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: drives mem_ack on the falling edge and retires every accepted write against the queue.
    initial begin : monitor
        logic a;
        wr_t  e;
        forever begin
            @(negedge I_CLK);
            case (ack_mode)
                0:       a = ($urandom_range(0, 9) < 7);
                2:       a = 1'b0;
                3:       a = (mem_addr[15:8] != 8'h78);
                default: a = 1'b1;
            endcase
            mem_ack = a;
            if (stall_valid && mem_wr) begin
                check_output("hold_addr", 32'(mem_addr), 32'(stall_addr));
                check_output("hold_data", 32'(mem_data), 32'(stall_data));
            end
            stall_valid = mem_wr && !a;
            stall_addr  = mem_addr;
            stall_data  = mem_data;
            if (mem_wr && a) begin
                while (exp_q.size() > 0 && exp_q[0].droppable && exp_q[0].addr != mem_addr)
                    void'(exp_q.pop_front());
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.droppable) body_seen++;
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        errors++;
                        $display("[TB] FAIL write actual=%h:%h required=%h:%h", mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
            if (!exec_allowed) check_output("exec_spurious", 32'(execute_enable), 0);
        end
    end

    task automatic send_byte(input logic [23:0] a, input logic [7:0] d, input bit honor);
        int guard = 0;
        while (honor && ioctl_wait && guard < 1000) begin
            @(negedge I_CLK);
            guard++;
        end
        if (guard >= 1000) check_output("wait_timeout", 32'(ioctl_wait), 0);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge I_CLK);
        ioctl_wr = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] typ, input logic [15:0] start, input int count);
        logic [7:0] d;
        for (int i = 0; i < count; i++) begin
            d = 8'($urandom);
            if (i == 21) d = typ;
            if (i == 22) d = start[7:0];
            if (i == 23) d = start[15:8];
            send_byte(24'(i), d, 1'b1);
        end
    endtask

    task automatic push_patches(input logic [7:0] typ, input logic [15:0] start, input logic [15:0] end_a);
        if (typ == BASIC) begin
            exp_q.push_back('{16'h78A5, start[15:8], 1'b0});
            exp_q.push_back('{16'h78A4, start[7:0], 1'b0});
            exp_q.push_back('{16'h78FA, end_a[15:8], 1'b0});
            exp_q.push_back('{16'h78F9, end_a[7:0], 1'b0});
            exp_q.push_back('{16'h78FC, end_a[15:8], 1'b0});
            exp_q.push_back('{16'h78FB, end_a[7:0], 1'b0});
            exp_q.push_back('{16'h78FE, end_a[15:8], 1'b0});
            exp_q.push_back('{16'h78FD, end_a[7:0], 1'b0});
        end else begin
            exp_q.push_back('{16'h788F, start[15:8], 1'b0});
            exp_q.push_back('{16'h788E, start[7:0], 1'b0});
        end
    endtask

    task automatic finish_exec(input logic [15:0] start);
        int guard = 0;
        while (!execute_enable && guard < 100) begin
            @(negedge I_CLK);
            guard++;
        end
        check_output("exec_enable", 32'(execute_enable), 1);
        check_output("exec_addr", 32'(execute_addr), 32'(start));
        check_output("exec_busy", 32'(busy), 1);
        repeat ($urandom_range(1, 4)) @(negedge I_CLK);
        check_output("exec_hold", 32'(execute_enable), 1);
        execute_ack = 1'b1;
        @(negedge I_CLK);
        execute_ack = 1'b0;
        check_output("exec_drop", 32'(execute_enable), 0);
        check_output("exec_idle", 32'(busy), 0);
        exec_allowed = 1'b0;
    endtask

    // One complete download; the reference model is the image itself: body at start+i, then the patch list.
    task automatic apply_stimulus(input logic [7:0] typ, input logic [15:0] start, input byte_q_t body,
                                  input int mode, input bit gaps);
        logic [15:0] sum = 16'h0000;
        logic [15:0] exp_sum;
        int guard = 0;
        ack_mode     = mode;
        exec_allowed = 1'b0;
        ioctl_download = 1'b1;
        @(negedge I_CLK);
        check_output("hdr_busy", 32'(busy), 1);
        check_output("hdr_led", 32'(led), 0);
        check_output("hdr_err_clear", 32'(load_error), 0);
        send_header(typ, start, HDR_LEN);
        check_output("body_led", 32'(led), 1);
        for (int i = 0; i < body.size(); i++) begin
            sum += {8'h00, body[i]};
            exp_q.push_back('{start + 16'(i), body[i], 1'b0});
            send_byte(24'(HDR_LEN + i), body[i], 1'b1);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge I_CLK);
        end
        push_patches(typ, start, start + 16'(body.size()));
        if (typ == MCODE) exec_allowed = 1'b1;
        ioctl_download = 1'b0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge I_CLK);
            guard++;
        end
        check_output("writes_done", 32'(exp_q.size()), 0);
        if (typ == MCODE) begin
            finish_exec(start);
        end else begin
            guard = 0;
            while (busy && guard < 100) begin
                @(negedge I_CLK);
                guard++;
            end
            check_output("basic_idle", 32'(busy), 0);
            check_output("basic_led", 32'(led), 0);
        end
        check_output("load_ok", 32'(load_error), 0);
`ifdef VZ_LOADER_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = 16'h0000;
`endif
        check_output("checksum", 32'(checksum), 32'(exp_sum));
    endtask

    task automatic overflow_test();
        int guard = 0;
        exec_allowed = 1'b0;
        body_seen    = 0;
        ack_mode     = 1;
        ioctl_download = 1'b1;
        @(negedge I_CLK);
        send_header(MCODE, 16'h9000, HDR_LEN);
        ack_mode = 2;
        check_output("ovf_wait_start", 32'(ioctl_wait), 0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{16'h9000 + 16'(i), 8'h50 + 8'(i), 1'b1});
            send_byte(24'(HDR_LEN + i), 8'h50 + 8'(i), 1'b0);
        end
        repeat (2) @(negedge I_CLK);
        check_output("ovf_wait_high", 32'(ioctl_wait), 1);
        check_output("ovf_error", 32'(load_error), 1);
        ack_mode = 1;
        push_patches(MCODE, 16'h9000, 16'h0000);
        exec_allowed = 1'b1;
        ioctl_download = 1'b0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge I_CLK);
            guard++;
        end
        check_output("ovf_writes_done", 32'(exp_q.size()), 0);
        check_output("ovf_min_kept", 32'(body_seen >= FIFO_DEPTH), 1);
        check_output("ovf_some_dropped", 32'(body_seen < 8), 1);
        finish_exec(16'h9000);
        check_output("ovf_error_sticky", 32'(load_error), 1);
        check_output("ovf_wait_idle", 32'(ioctl_wait), 0);
    endtask

    initial begin
        byte_q_t body;
        logic [7:0]  typ;
        logic [15:0] start;
        int guard;
        I_RST = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = 24'h0;
        ioctl_data = 8'h00;
        execute_ack = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(negedge I_CLK);
        check_output("rst_mem_addr", 32'(mem_addr), 0);
        check_output("rst_mem_data", 32'(mem_data), 0);
        check_output("rst_mem_wr", 32'(mem_wr), 0);
        check_output("rst_exec_addr", 32'(execute_addr), 0);
        check_output("rst_exec_en", 32'(execute_enable), 0);
        check_output("rst_wait", 32'(ioctl_wait), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_led", 32'(led), 0);
        check_output("rst_error", 32'(load_error), 0);
        check_output("rst_checksum", 32'(checksum), 0);
        I_RST = 1'b0;
        @(negedge I_CLK);

        $display("[TB] directed BASIC and MCODE images");
        body = '{8'h11, 8'h22, 8'h33};
        apply_stimulus(BASIC, 16'h7AE9, body, 1, 1'b0);
        body = '{8'hA5, 8'h5A};
        apply_stimulus(MCODE, 16'h8000, body, 1, 1'b0);
        body = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_stimulus(BASIC, 16'hFFFE, body, 0, 1'b1);

        $display("[TB] backpressure and overflow");
        overflow_test();

        $display("[TB] bad type byte");
        ack_mode = 1;
        exec_allowed = 1'b0;
        ioctl_download = 1'b1;
        @(negedge I_CLK);
        send_header(8'h42, 16'h1234, HDR_LEN);
        check_output("badtype_busy", 32'(busy), 0);
        check_output("badtype_led", 32'(led), 0);
        check_output("badtype_error", 32'(load_error), 1);
        for (int i = 0; i < 3; i++) send_byte(24'(HDR_LEN + i), 8'(i), 1'b0);
        ioctl_download = 1'b0;
        repeat (5) @(negedge I_CLK);
        check_output("badtype_error_hold", 32'(load_error), 1);
        body = '{8'h77};
        apply_stimulus(MCODE, 16'h4000, body, 1, 1'b0);

        $display("[TB] download dropped inside header");
        ioctl_download = 1'b1;
        @(negedge I_CLK);
        send_header(BASIC, 16'h7000, 11);
        ioctl_download = 1'b0;
        @(negedge I_CLK);
        check_output("drop_busy", 32'(busy), 0);
        check_output("drop_error", 32'(load_error), 1);
        repeat (5) @(negedge I_CLK);

        $display("[TB] reset during patch");
        ack_mode = 3;
        ioctl_download = 1'b1;
        @(negedge I_CLK);
        send_header(BASIC, 16'h6000, HDR_LEN);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{16'h6000 + 16'(i), 8'hC0 + 8'(i), 1'b0});
            send_byte(24'(HDR_LEN + i), 8'hC0 + 8'(i), 1'b1);
        end
        ioctl_download = 1'b0;
        guard = 0;
        while (!(mem_wr && mem_addr == 16'h78A5) && guard < 200) begin
            @(negedge I_CLK);
            guard++;
        end
        check_output("patch_reached", 32'(mem_wr && mem_addr == 16'h78A5), 1);
        check_output("patch_body_done", 32'(exp_q.size()), 0);
        #2 I_RST = 1'b1;
        #1;
        check_output("prst_mem_wr", 32'(mem_wr), 0);
        check_output("prst_mem_addr", 32'(mem_addr), 0);
        check_output("prst_mem_data", 32'(mem_data), 0);
        check_output("prst_busy", 32'(busy), 0);
        check_output("prst_led", 32'(led), 0);
        exp_q.delete();
        @(negedge I_CLK);
        I_RST = 1'b0;
        ack_mode = 1;
        for (int i = 0; i < 5; i++) send_byte(24'(HDR_LEN + i), 8'(i), 1'b0);
        repeat (20) @(negedge I_CLK);
        check_output("prst_still_idle", 32'(busy), 0);

        $display("[TB] randomized images");
        for (int n = 0; n < 16; n++) begin
            typ   = $urandom_range(0, 1) ? BASIC : MCODE;
            start = 16'($urandom);
            if (n % 4 == 0) start = 16'hFFF8 + 16'($urandom_range(0, 7));
            body.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) body.push_back(8'($urandom));
            apply_stimulus(typ, start, body, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
